// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: interrupt controller for a bank of down-counter timer channels.
// Every channel's irq_in line goes through a rising-edge detector. A detected
// event latches a pending flag. A three-state FSM (IDLE/REQ/CLR) presents the
// lowest-indexed pending channel that is enabled in the mask, and waits for the
// handler to acknowledge it.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   irq_in     - [N_CH] interrupt lines from the timer channels
//   mask_we    - write strobe for the enable mask
//   mask_wdata - [N_CH] new mask value (1 = channel enabled)
//   ack        - one-cycle handler acknowledge, honoured only while requesting
//   miss_clr   - clears the overflow flags and the miss counter
//   irq_out    - interrupt request to the handler
//   irq_id     - [clog2(N_CH)] index of the requested channel
//   pending    - [N_CH] latched, unserviced events
//   overflow   - [N_CH] sticky lost-event flags
//   miss_cnt   - [8] saturating lost-event count
//
// Build option: define TIMER_IRQ_MISS_CNT_EN to include the miss counter.
// When it is undefined, miss_cnt is tied to zero. Overflow flags are present
// in both builds.
module timer_irq_ctrl #(
   parameter int unsigned N_CH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         irq_in,
   input  logic                    mask_we,
   input  logic [N_CH-1:0]         mask_wdata,
   input  logic                    ack,
   input  logic                    miss_clr,
   output logic                    irq_out,
   output logic [$clog2(N_CH)-1:0] irq_id,
   output logic [N_CH-1:0]         pending,
   output logic [N_CH-1:0]         overflow,
   output logic [7:0]              miss_cnt
);

   localparam int unsigned ID_W = $clog2(N_CH);

   typedef enum logic [1:0] {IDLE, REQ, CLR} state_t;

   state_t          state;
   logic [N_CH-1:0] irq_prev;
   logic [N_CH-1:0] mask;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] clr_vec;
   logic [N_CH-1:0] lost;
   logic [N_CH-1:0] eligible;
   logic            sel_valid;
   logic [ID_W-1:0] sel_id;

   always_comb begin
      rise    = irq_in & ~irq_prev;
      clr_vec = '0;
      if (state == REQ && ack)
         clr_vec[irq_id] = 1'b1;
      // A new event on the channel being acknowledged replaces the cleared
      // event. It is not counted as lost.
      lost     = rise & pending & ~clr_vec;
      eligible = pending & mask;
      sel_valid = 1'b0;
      sel_id    = '0;
      // Scan from the top index down so that the lowest set index wins.
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (eligible[i-1]) begin
            sel_valid = 1'b1;
            sel_id    = ID_W'(i-1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         irq_prev <= '0;
         mask     <= '1;
         pending  <= '0;
         overflow <= '0;
         irq_out  <= 1'b0;
         irq_id   <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~clr_vec) | rise;
         overflow <= miss_clr ? lost : (overflow | lost);
         if (mask_we)
            mask <= mask_wdata;
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  irq_id  <= sel_id;
                  irq_out <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (ack) begin
                  irq_out <= 1'b0;
                  state   <= CLR;
               end
            end
            CLR: begin
               irq_out <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               irq_out <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifdef TIMER_IRQ_MISS_CNT_EN
   logic [3:0] lost_cnt;
   logic [8:0] miss_sum;

   always_comb begin
      lost_cnt = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         lost_cnt = lost_cnt + 4'(lost[i]);
      miss_sum = {1'b0, miss_cnt} + 9'(lost_cnt);
   end

   // When a clear and a loss happen in the same cycle, the clear is applied
   // first and the losses of that cycle are then counted.
   always_ff @(posedge clk) begin
      if (reset)
         miss_cnt <= '0;
      else if (miss_clr)
         miss_cnt <= 8'(lost_cnt);
      else
         miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
   end
`else
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

   localparam int N = 4;
`ifdef TIMER_IRQ_MISS_CNT_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic [N-1:0] irq_in;
   logic         mask_we;
   logic [N-1:0] mask_wdata;
   logic         ack;
   logic         miss_clr;
   logic         irq_out;
   logic [1:0]   irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] overflow;
   logic [7:0]   miss_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   timer_irq_ctrl #(.N_CH(N)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .ack(ack), .miss_clr(miss_clr),
      .irq_out(irq_out), .irq_id(irq_id), .pending(pending),
      .overflow(overflow), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference model. The handler is described by a phase:
   // 0 = idle, 1 = requesting, 2 = one-cycle gap after an acknowledge.
   int       m_phase;
   int       m_id;
   bit       m_pend [N];
   bit       m_ovf  [N];
   bit       m_mask [N];
   bit       m_prev [N];
   int       m_miss;

   task automatic model_edge(input logic [N-1:0] irq, input logic mwe,
                             input logic [N-1:0] mwd, input logic a,
                             input logic mc, input logic r);
      int  cleared;
      int  nlost;
      int  sel;
      bit  new_pend [N];
      bit  lost_now [N];
      if (r) begin
         m_phase = 0; m_id = 0; m_miss = 0;
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
         end
         return;
      end
      cleared = (m_phase == 1 && a) ? m_id : -1;
      nlost = 0;
      for (int i = 0; i < N; i++) begin
         new_pend[i] = m_pend[i];
         lost_now[i] = 0;
         if (i == cleared) new_pend[i] = 0;
         if (irq[i] && !m_prev[i]) begin
            if (m_pend[i] && i != cleared) begin
               lost_now[i] = 1;
               nlost++;
            end
            new_pend[i] = 1;
         end
      end
      for (int i = 0; i < N; i++)
         m_ovf[i] = mc ? lost_now[i] : (m_ovf[i] | lost_now[i]);
      if (MISS_EN) begin
         if (mc) m_miss = nlost;
         else    m_miss = (m_miss + nlost > 255) ? 255 : m_miss + nlost;
      end else begin
         m_miss = 0;
      end
      case (m_phase)
         0: begin
            sel = -1;
            for (int i = 0; i < N; i++)
               if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
            if (sel >= 0) begin
               m_phase = 1;
               m_id = sel;
            end
         end
         1: if (a) m_phase = 2;
         default: m_phase = 0;
      endcase
      for (int i = 0; i < N; i++) begin
         m_pend[i] = new_pend[i];
         if (mwe) m_mask[i] = mwd[i];
         m_prev[i] = irq[i];
      end
   endtask

   function automatic logic [18:0] model_outs();
      logic [N-1:0] p, o;
      for (int i = 0; i < N; i++) begin
         p[i] = m_pend[i];
         o[i] = m_ovf[i];
      end
      return {(m_phase == 1), 2'(m_id), p, o, 8'(m_miss)};
   endfunction

   function automatic logic [18:0] dut_outs();
      return {irq_out, irq_id, pending, overflow, miss_cnt};
   endfunction

   task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got out=%0b id=%0d pend=%b ovf=%b miss=%0d, expected out=%0b id=%0d pend=%b ovf=%b miss=%0d",
                  name, act[18], act[17:16], act[15:12], act[11:8], act[7:0],
                  exp[18], exp[17:16], exp[15:12], exp[11:8], exp[7:0]);
      end
   endtask

   task automatic step(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                       input logic a, input logic mc, input logic r);
      irq_in = irq; mask_we = mwe; mask_wdata = mwd; ack = a; miss_clr = mc; reset = r;
      @(posedge clk);
      model_edge(irq, mwe, mwd, a, mc, r);
      #1;
      chk("model", dut_outs(), model_outs());
   endtask

   typedef struct {
      logic [N-1:0] irq;
      logic         mwe;
      logic [N-1:0] mwd;
      logic         a;
      logic         mc;
      logic         r;
      logic         eout;
      logic [1:0]   eid;
      logic [N-1:0] epend;
      logic [N-1:0] eovf;
      logic [7:0]   emiss;
   } vec_t;

   vec_t tbl [24];
   logic [7:0] miss1;
   logic [7:0] misssat;

   initial begin
      miss1   = MISS_EN ? 8'd1 : 8'd0;
      misssat = MISS_EN ? 8'hFF : 8'h00;
      irq_in = '0; mask_we = 0; mask_wdata = '0; ack = 0; miss_clr = 0; reset = 1;

      //          irq    mwe mwd    a  mc r  out id pend   ovf    miss
      tbl[0]  = '{4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 8'd0};
      // single event on channel 2
      tbl[1]  = '{4'h4, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0100, 4'b0000, 8'd0};
      tbl[2]  = '{4'h4, 0, 4'h0, 0, 0, 0, 1, 2, 4'b0100, 4'b0000, 8'd0};
      tbl[3]  = '{4'h0, 0, 4'h0, 1, 0, 0, 0, 2, 4'b0000, 4'b0000, 8'd0};
      tbl[4]  = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 2, 4'b0000, 4'b0000, 8'd0};
      tbl[5]  = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 2, 4'b0000, 4'b0000, 8'd0};
      // priority: channels 1 and 3 together
      tbl[6]  = '{4'hA, 0, 4'h0, 0, 0, 0, 0, 2, 4'b1010, 4'b0000, 8'd0};
      tbl[7]  = '{4'hA, 0, 4'h0, 0, 0, 0, 1, 1, 4'b1010, 4'b0000, 8'd0};
      tbl[8]  = '{4'h0, 0, 4'h0, 1, 0, 0, 0, 1, 4'b1000, 4'b0000, 8'd0};
      tbl[9]  = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 1, 4'b1000, 4'b0000, 8'd0};
      tbl[10] = '{4'h0, 0, 4'h0, 0, 0, 0, 1, 3, 4'b1000, 4'b0000, 8'd0};
      tbl[11] = '{4'h0, 0, 4'h0, 1, 0, 0, 0, 3, 4'b0000, 4'b0000, 8'd0};
      tbl[12] = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 3, 4'b0000, 4'b0000, 8'd0};
      // mask channel 0 off, latch an event, then re-enable it
      tbl[13] = '{4'h0, 1, 4'hE, 0, 0, 0, 0, 3, 4'b0000, 4'b0000, 8'd0};
      tbl[14] = '{4'h1, 0, 4'h0, 0, 0, 0, 0, 3, 4'b0001, 4'b0000, 8'd0};
      tbl[15] = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 3, 4'b0001, 4'b0000, 8'd0};
      tbl[16] = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 3, 4'b0001, 4'b0000, 8'd0};
      tbl[17] = '{4'h0, 1, 4'hF, 0, 0, 0, 0, 3, 4'b0001, 4'b0000, 8'd0};
      tbl[18] = '{4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 4'b0001, 4'b0000, 8'd0};
      tbl[19] = '{4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 8'd0};
      tbl[20] = '{4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 8'd0};
      // overflow on channel 1 while it is being requested
      tbl[21] = '{4'h2, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 8'd0};
      tbl[22] = '{4'h0, 0, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'b0000, 8'd0};
      tbl[23] = '{4'h2, 0, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'b0010, miss1};

      for (int k = 0; k < 24; k++) begin
         step(tbl[k].irq, tbl[k].mwe, tbl[k].mwd, tbl[k].a, tbl[k].mc, tbl[k].r);
         chk($sformatf("vec%0d", k), dut_outs(),
             {tbl[k].eout, tbl[k].eid, tbl[k].epend, tbl[k].eovf, tbl[k].emiss});
      end

      // 299 further losses on channel 1 (300 in total) saturate the counter
      for (int k = 0; k < 299; k++) begin
         step(4'h0, 0, 4'h0, 0, 0, 0);
         step(4'h2, 0, 4'h0, 0, 0, 0);
      end
      chk("saturate", dut_outs(), {1'b1, 2'd1, 4'b0010, 4'b0010, misssat});
      step(4'h0, 0, 4'h0, 0, 1, 0);
      chk("miss_clr", dut_outs(), {1'b1, 2'd1, 4'b0010, 4'b0000, 8'd0});
      step(4'h0, 0, 4'h0, 1, 0, 0);
      step(4'h0, 0, 4'h0, 0, 0, 0);

      // a channel 2 event coinciding with the acknowledge of channel 2
      step(4'h4, 0, 4'h0, 0, 0, 0);
      step(4'h0, 0, 4'h0, 0, 0, 0);
      chk("coin_req", dut_outs(), {1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0});
      step(4'h4, 0, 4'h0, 1, 0, 0);
      chk("coin_ack", dut_outs(), {1'b0, 2'd2, 4'b0100, 4'b0000, 8'd0});
      step(4'h0, 0, 4'h0, 0, 0, 0);
      step(4'h0, 0, 4'h0, 0, 0, 0);
      chk("coin_rereq", dut_outs(), {1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0});
      // clearing the mask does not withdraw the active request
      step(4'h0, 1, 4'h0, 0, 0, 0);
      chk("mask_hold", dut_outs(), {1'b1, 2'd2, 4'b0100, 4'b0000, 8'd0});
      // reset during the request; irq_in held high through the reset
      step(4'h1, 0, 4'h0, 0, 0, 1);
      chk("rst_req", dut_outs(), {1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0});
      step(4'h1, 0, 4'h0, 0, 0, 0);
      chk("rst_held", dut_outs(), {1'b0, 2'd0, 4'b0001, 4'b0000, 8'd0});
      step(4'h1, 0, 4'h0, 0, 0, 0);
      chk("rst_mask", dut_outs(), {1'b1, 2'd0, 4'b0001, 4'b0000, 8'd0});
      step(4'h0, 0, 4'h0, 1, 0, 0);

      // randomized traffic against the reference model
      for (int k = 0; k < 600; k++) begin
         step(4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 149) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001: Parameter N_CH, default 4, number of timer interrupt channels; supported values 2..8.
REQ-002: clk  input  1  single clock; all logic samples on the rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: irq_in  input  N_CH  interrupt lines from down-counter channels; bit i is the interrupt output of channel i.
REQ-005: mask_we  input  1  write strobe for the enable mask.
REQ-006: mask_wdata  input  N_CH  new mask value; 1 enables the channel.
REQ-007: ack  input  1  handler acknowledge; a one-cycle pulse.
REQ-008: miss_clr  input  1  clears overflow flags and the miss counter.
REQ-009: irq_out  output  1  interrupt request to the handler.
REQ-010: irq_id  output  clog2(N_CH)  index of the channel being requested.
REQ-011: pending  output  N_CH  latched, unserviced interrupt flags.
REQ-012: overflow  output  N_CH  sticky flag per channel; set when an event arrives while that channel is already pending.
REQ-013: miss_cnt  output  8  saturating count of lost events.

Function
REQ-014: Each irq_in bit SHALL be rising-edge detected against a registered copy of its previous value; a level held high SHALL count as one event.
REQ-015: An event on channel i SHALL set pending[i] at the clock edge that samples the rise.
REQ-016: The FSM SHALL have three states: IDLE, REQ and CLR.
REQ-017: IDLE: if (pending & mask) != 0, select the lowest set index, register it into irq_id, and go to REQ; otherwise stay in IDLE.
REQ-018: REQ: irq_out=1 and irq_id is held stable; on ack=1, clear pending[irq_id] and go to CLR; otherwise stay in REQ.
REQ-019: CLR: irq_out=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-020: irq_out SHALL be 0 in IDLE and CLR.
REQ-021: Latency: a rise sampled at edge N SHALL give pending at N and irq_out=1 after edge N+1, provided the FSM is in IDLE and the channel is unmasked.
REQ-022: ack outside REQ SHALL be ignored.
REQ-023: Clearing a mask bit during REQ SHALL NOT withdraw the active request.
REQ-024: Masked channels SHALL still latch pending but SHALL NOT be selected.
REQ-025: mask_we SHALL update the mask at the next edge; the new value takes effect for the following selection.
REQ-026: If an event on channel i arrives while pending[i]=1 and pending[i] is not being cleared that cycle, overflow[i] SHALL be set and the event lost.
REQ-027: If the event coincides with the ack clear of the same channel, pending[i] SHALL remain 1 (the event wins) and no overflow SHALL occur.
REQ-028: miss_cnt SHALL increment by the number of lost events in a cycle and saturate at 8'hFF.
REQ-029: miss_clr SHALL zero overflow and miss_cnt; a loss in the same cycle takes priority (flag set, count=number lost).

Reset
REQ-030: Reset SHALL clear pending, overflow, miss_cnt, irq_out, irq_id and the edge-detect registers to 0.
REQ-031: Reset SHALL set the mask to all ones and the FSM to IDLE.
REQ-032: Reset mid-request SHALL drop irq_out at the reset edge; events in the reset cycle SHALL be discarded.
REQ-033: An irq_in held high through reset SHALL generate an event on the first post-reset edge.

Configuration
REQ-034: Macro TIMER_IRQ_MISS_CNT_EN: when defined, miss_cnt SHALL operate per REQ-028/029; when undefined, the counter logic SHALL be omitted and miss_cnt SHALL be tied to 8'h00; overflow SHALL behave identically in both builds.

Verification
REQ-035: Single event: irq_in=4'b0100 from reset -> pending=4'b0100, then irq_out=1 with irq_id=2 one edge later; ack -> pending=0, irq_out=0 for one cycle, FSM returns to IDLE.
REQ-036: Priority: rises on channels 1 and 3 in the same cycle -> irq_id=1 first; after ack and the CLR cycle -> irq_id=3.
REQ-037: Mask: mask=4'b1110 with an event on channel 0 -> pending[0]=1 and irq_out stays 0; writing mask=4'hF -> irq_out=1 with irq_id=0.
REQ-038: Overflow: a second rise on channel 1 while pending[1]=1 -> overflow=4'b0010 and miss_cnt=1 (0 without the macro); 300 losses -> miss_cnt=8'hFF; miss_clr -> both return to 0.
REQ-039: Coincidence and reset: a channel 2 rise in the same cycle as its ack -> pending[2] stays 1 with no overflow; asserting reset during REQ -> irq_out=0 and mask=4'hF at the next edge.
